// File: rtl/wb_regfile.sv
// Write-back stage and 32x32 architectural register file (x0 reads zero) with committed-write counter.
// Define WB_REGFILE_BYPASS_EN to forward the in-flight write-back value onto the read ports.
module wb_regfile (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_adv,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] load_data_in,
  input  logic [4:0]  rd_in,
  input  logic        wb_reg_file_in,
  input  logic        memtoreg_in,
  input  logic [4:0]  rs1_addr,
  input  logic [4:0]  rs2_addr,
  output logic [31:0] rs1_data,
  output logic [31:0] rs2_data,
  output logic [31:0] wb_data,
  output logic        wb_we,
  output logic [31:0] wr_count
);

  logic [31:0] regs_q [32];
  logic [31:0] wr_count_q;
  logic [31:0] wr_count_d;

  assign wb_data    = memtoreg_in ? load_data_in : alu_result_in;
  assign wb_we      = rst_n & wb_adv & wb_reg_file_in & (rd_in != 5'd0);
  assign wr_count_d = wr_count_q + 32'd1;
  assign wr_count   = wr_count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
      wr_count_q <= '0;
    end else if (wb_we) begin
      regs_q[rd_in] <= wb_data;
      wr_count_q    <= wr_count_d;
    end
  end

  // Address 0 short-circuits ahead of both stored state and bypass.
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      rs1_data = regs_q[rs1_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_we && (rs1_addr == rd_in)) rs1_data = wb_data;
`endif
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      rs2_data = regs_q[rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (wb_we && (rs2_addr == rd_in)) rs2_data = wb_data;
`endif
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: driver pushes expected outputs per cycle, negedge monitor compares.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wb_adv;
  logic [31:0] alu_result_in;
  logic [31:0] load_data_in;
  logic [4:0]  rd_in;
  logic        wb_reg_file_in;
  logic        memtoreg_in;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] wb_data;
  logic        wb_we;
  logic [31:0] wr_count;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  wb_regfile dut (
    .clk(clk), .rst_n(rst_n), .wb_adv(wb_adv),
    .alu_result_in(alu_result_in), .load_data_in(load_data_in),
    .rd_in(rd_in), .wb_reg_file_in(wb_reg_file_in), .memtoreg_in(memtoreg_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .wb_data(wb_data), .wb_we(wb_we), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] wd;
    logic        we;
    logic [31:0] cnt;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] m [32];
  logic [31:0] m_cnt;

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] rd, input logic [31:0] wd);
    if (a == 0) return 32'd0;
    if (BYP && we && a == rd) return wd;
    return m[a];
  endfunction

  task automatic cmp(input string name, input string tag, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s.%s actual=%08h required=%08h", tag, name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp("rs1_data", e.tag, rs1_data, e.r1);
      cmp("rs2_data", e.tag, rs2_data, e.r2);
      cmp("wb_data",  e.tag, wb_data,  e.wd);
      cmp("wb_we",    e.tag, {31'd0, wb_we}, {31'd0, e.we});
      cmp("wr_count", e.tag, wr_count, e.cnt);
    end
  end

  // Called just after a rising edge; drives one cycle, queues its expectation, then advances the model.
  task automatic step(input bit chk, input logic rst, input logic adv, input logic wr, input logic mtr,
                      input logic [4:0] rd, input logic [4:0] a1, input logic [4:0] a2,
                      input logic [31:0] alu, input logic [31:0] ld, input string tag);
    exp_t e;
    rst_n = rst; wb_adv = adv; wb_reg_file_in = wr; memtoreg_in = mtr;
    rd_in = rd; rs1_addr = a1; rs2_addr = a2; alu_result_in = alu; load_data_in = ld;
    e.wd  = mtr ? ld : alu;
    e.we  = rst && adv && wr && (rd != 0);
    e.r1  = model_read(a1, e.we, rd, e.wd);
    e.r2  = model_read(a2, e.we, rd, e.wd);
    e.cnt = m_cnt;
    e.tag = tag;
    if (chk) sb.push_back(e);
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 32; i++) m[i] = 32'd0;
      m_cnt = 32'd0;
    end else if (e.we) begin
      m[rd] = e.wd;
      m_cnt = m_cnt + 32'd1;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m[i] = 32'd0;
    m_cnt = 32'd0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, "rst0");
    step(1, 0, 1, 1, 0, 5'd4, 5'd4, 5'd0, 32'h1, 32'h2, "rst1");

    for (int i = 0; i < 32; i++)
      step(1, 1, 0, 0, 0, 0, 5'(i), 5'(31 - i), 0, 0, "rd_all");

    step(1, 1, 1, 1, 0, 5'd5, 5'd5, 5'd0, 32'hDEADBEEF, 32'h12345678, "wr_alu");
    step(1, 1, 0, 0, 0, 0, 5'd5, 5'd5, 0, 0, "rd_alu");
    step(1, 1, 1, 1, 1, 5'd5, 5'd0, 5'd1, 32'hDEADBEEF, 32'h12345678, "wr_ld");
    step(1, 1, 0, 0, 0, 0, 5'd5, 5'd0, 0, 0, "rd_ld");

    step(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFF, 0, "wr_x0");
    step(1, 1, 0, 0, 0, 0, 5'd0, 5'd5, 0, 0, "rd_x0");

    for (int i = 0; i < 3; i++)
      step(1, 1, 0, 1, 0, 5'd7, 5'd7, 5'd7, 32'hA5A5A5A5, 0, "hold");
    step(1, 1, 1, 1, 0, 5'd7, 5'd7, 5'd0, 32'hA5A5A5A5, 0, "adv");
    step(1, 1, 0, 0, 0, 0, 5'd7, 5'd7, 0, 0, "rd_x7");

    step(1, 1, 1, 1, 0, 5'd3, 5'd0, 5'd0, 32'h11, 0, "x3_pre");
    step(1, 1, 1, 1, 0, 5'd3, 5'd3, 5'd3, 32'h42, 0, "rdw");
    step(1, 1, 0, 0, 0, 0, 5'd3, 5'd3, 0, 0, "rdw_after");

    // Preload the counter near its wrap point instead of committing 2^32 writes.
    dut.wr_count_q = 32'hFFFFFFFE;
    m_cnt = 32'hFFFFFFFE;
    step(1, 1, 1, 1, 0, 5'd8, 5'd8, 5'd0, 32'h8, 0, "wrap_a");
    step(1, 1, 1, 1, 0, 5'd8, 5'd8, 5'd0, 32'h9, 0, "wrap_b");
    step(1, 1, 0, 0, 0, 0, 5'd8, 5'd0, 0, 0, "wrap_c");

    step(1, 1, 1, 1, 0, 5'd9, 5'd9, 5'd0, 32'h99, 0, "x9_pre");
    step(1, 0, 1, 1, 0, 5'd9, 5'd9, 5'd8, 32'h77, 0, "rst_wr");
    step(1, 1, 0, 0, 0, 0, 5'd9, 5'd8, 0, 0, "rst_after");

    for (int n = 0; n < 400; n++) begin
      logic [4:0] rd, a1, a2;
      rd = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? rd : 5'($urandom_range(0, 31));
      step(1, ($urandom_range(0, 49) != 0), 1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom),
           rd, a1, a2, $urandom, $urandom, "rand");
    end

    step(1, 1, 0, 0, 0, 0, 5'd0, 5'd0, 0, 0, "tail");
    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
